// File: rtl/fwd_pkg.sv
// Shared types for the operand-forwarding / load-use hazard unit.
package fwd_pkg;

    localparam int unsigned XLEN_P = 32;
    localparam int unsigned REG_W  = 5;
    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [2:0] {
        SRC_REGFILE = 3'd0,
        SRC_EX      = 3'd1,
        SRC_MA      = 3'd2,
        SRC_HIST0   = 3'd3,
        SRC_HIST1   = 3'd4,
        SRC_HIST2   = 3'd5,
        SRC_HIST3   = 3'd6
    } fwd_src_e;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rd;
        logic [XLEN_P-1:0] data;
    } hist_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID/EX forwarding bus: pipeline-side inputs and resolved operands/stall.
interface fwd_hazard_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = 32
);
    logic                     advance;
    logic [NUM_RD*5-1:0]      rs_id;
    logic [NUM_RD-1:0]        rs_used;
    logic [NUM_RD*XLEN-1:0]   opnd_id;
    logic [4:0]               rd_ex;
    logic                     reg_we_ex;
    logic                     is_load_ex;
    logic [XLEN-1:0]          alu_result;
    logic [4:0]               rd_ma;
    logic                     reg_we_ma;
    logic [XLEN-1:0]          reg_wdata;
    logic [NUM_RD*XLEN-1:0]   opnd;
    logic [NUM_RD*3-1:0]      fwd_src;
    logic                     stall;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output advance, rs_id, rs_used, opnd_id, rd_ex, reg_we_ex, is_load_ex,
               alu_result, rd_ma, reg_we_ma, reg_wdata,
        input  opnd, fwd_src, stall, stall_cnt
    );

    modport slave (
        input  advance, rs_id, rs_used, opnd_id, rd_ex, reg_we_ex, is_load_ex,
               alu_result, rd_ma, reg_we_ma, reg_wdata,
        output opnd, fwd_src, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_port_mux.sv
// Priority forwarding select for one source operand (EX > MA > history > regfile).
module fwd_port_mux
    import fwd_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_P,
    parameter int unsigned HIST_DEPTH = 2
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] opnd_id,
    input  logic [4:0]      rd_ex,
    input  logic            reg_we_ex,
    input  logic            is_load_ex,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      rd_ma,
    input  logic            reg_we_ma,
    input  logic [XLEN-1:0] reg_wdata,
    input  hist_entry_t     hist [HIST_DEPTH],
    output logic [XLEN-1:0] opnd_c,
    output fwd_src_e        fwd_src_c,
    output logic            load_hit_c
);

    logic hist_found;

    // A load match in EX claims the operand but supplies no data; the stall covers it.
    always_comb begin
        opnd_c     = opnd_id;
        fwd_src_c  = SRC_REGFILE;
        load_hit_c = 1'b0;
        hist_found = 1'b0;
        if (rs != REG_X0) begin
            if (reg_we_ex && (rd_ex == rs)) begin
                if (is_load_ex) begin
                    load_hit_c = 1'b1;
                end else begin
                    opnd_c    = alu_result;
                    fwd_src_c = SRC_EX;
                end
            end else if (reg_we_ma && (rd_ma == rs)) begin
                opnd_c    = reg_wdata;
                fwd_src_c = SRC_MA;
            end else begin
                for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                    if (!hist_found && hist[i].valid && (hist[i].rd == rs)) begin
                        hist_found = 1'b1;
                        opnd_c     = XLEN'(hist[i].data);
                        fwd_src_c  = fwd_src_e'(3'(int'(SRC_HIST0) + i));
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall detection between ID and EX,
// with a committed-writeback history and a saturating stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_P,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned HIST_DEPTH = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    fwd_hazard_unit_if.slave bus
);

    hist_entry_t      hist_q [HIST_DEPTH];
    hist_entry_t      hist_d [HIST_DEPTH];
    logic [XLEN-1:0]  opnd_arr [NUM_RD];
    fwd_src_e         src_arr [NUM_RD];
    logic             load_hit_arr [NUM_RD];
    logic             stall_c;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_port
        fwd_port_mux #(
            .XLEN       (XLEN),
            .HIST_DEPTH (HIST_DEPTH)
        ) u_mux (
            .rs         (bus.rs_id[5*k +: 5]),
            .opnd_id    (bus.opnd_id[XLEN*k +: XLEN]),
            .rd_ex      (bus.rd_ex),
            .reg_we_ex  (bus.reg_we_ex),
            .is_load_ex (bus.is_load_ex),
            .alu_result (bus.alu_result),
            .rd_ma      (bus.rd_ma),
            .reg_we_ma  (bus.reg_we_ma),
            .reg_wdata  (bus.reg_wdata),
            .hist       (hist_q),
            .opnd_c     (opnd_arr[k]),
            .fwd_src_c  (src_arr[k]),
            .load_hit_c (load_hit_arr[k])
        );
    end

    // Pack per-port results; only ports that really read their operand can stall.
    always_comb begin
        bus.opnd    = '0;
        bus.fwd_src = '0;
        stall_c     = 1'b0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            bus.opnd[XLEN*k +: XLEN] = opnd_arr[k];
            bus.fwd_src[3*k +: 3]    = src_arr[k];
            stall_c                  = stall_c | (load_hit_arr[k] & bus.rs_used[k]);
        end
    end

    assign bus.stall     = stall_c;
    assign bus.stall_cnt = stall_cnt_q;

    // History shifts only when MA retires, so a frozen pipeline never duplicates entries.
    always_comb begin
        hist_d      = hist_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.advance) begin
            hist_d[0].valid = bus.reg_we_ma && (bus.rd_ma != REG_X0);
            hist_d[0].rd    = bus.rd_ma;
            hist_d[0].data  = XLEN_P'(bus.reg_wdata);
            for (int i = 1; i < int'(HIST_DEPTH); i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                hist_q[i].valid <= 1'b0;
            end
            stall_cnt_q <= '0;
        end else begin
            hist_q      <= hist_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus random traffic against a retirement-list model.
module tb_fwd_hazard_unit;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_RD     = 2;
    localparam int unsigned HIST_DEPTH = 2;
    localparam int unsigned CNT_W      = 4;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct {
        bit          valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } ret_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.XLEN(XLEN), .NUM_RD(NUM_RD), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(
        .XLEN(XLEN), .NUM_RD(NUM_RD), .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ret_t retired[$];   // newest retirement at index 0
    int   m_cnt;
    int   n_checks;
    int   n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Resolve one operand straight from the forwarding rules.
    function automatic void model_port(input int k, output logic [31:0] o,
                                       output logic [2:0] src, output bit lh);
        logic [4:0] rs;
        rs  = bus.rs_id[5*k +: 5];
        o   = bus.opnd_id[XLEN*k +: XLEN];
        src = 3'd0;
        lh  = 1'b0;
        if (rs == 5'd0) return;
        if (bus.reg_we_ex && bus.rd_ex == rs) begin
            if (bus.is_load_ex) lh = 1'b1;
            else begin o = bus.alu_result; src = 3'd1; end
            return;
        end
        if (bus.reg_we_ma && bus.rd_ma == rs) begin
            o = bus.reg_wdata; src = 3'd2;
            return;
        end
        for (int i = 0; i < retired.size() && i < int'(HIST_DEPTH); i++) begin
            if (retired[i].valid && retired[i].rd == rs) begin
                o = retired[i].data; src = 3'(3 + i);
                return;
            end
        end
    endfunction

    function automatic bit model_stall();
        logic [31:0] o;
        logic [2:0]  s;
        bit          lh;
        bit          st = 1'b0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            model_port(k, o, s, lh);
            if (lh && bus.rs_used[k]) st = 1'b1;
        end
        return st;
    endfunction

    task automatic check_outputs();
        logic [31:0] o;
        logic [2:0]  s;
        bit          lh;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            model_port(k, o, s, lh);
            if (!lh) check_eq($sformatf("opnd%0d", k), 64'(bus.opnd[XLEN*k +: XLEN]), 64'(o));
            check_eq($sformatf("src%0d", k), 64'(bus.fwd_src[3*k +: 3]), 64'(s));
        end
        check_eq("stall", 64'(bus.stall), 64'(model_stall()));
        check_eq("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    endtask

    // Check (optionally), then advance the model across one rising edge.
    task automatic tick(input bit do_check);
        bit st;
        #1;
        if (do_check) check_outputs();
        st = model_stall();
        @(posedge clk);
        if (reset) begin
            retired.delete();
            m_cnt = 0;
        end else begin
            if (st && m_cnt < CNT_MAX) m_cnt++;
            if (bus.advance) begin
                retired.push_front('{valid: bus.reg_we_ma && bus.rd_ma != 5'd0,
                                     rd: bus.rd_ma, data: bus.reg_wdata});
                if (retired.size() > int'(HIST_DEPTH)) void'(retired.pop_back());
            end
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.advance    = 1'b0;
        bus.rs_id      = '0;
        bus.rs_used    = '1;
        bus.opnd_id    = '0;
        bus.rd_ex      = '0;
        bus.reg_we_ex  = 1'b0;
        bus.is_load_ex = 1'b0;
        bus.alu_result = '0;
        bus.rd_ma      = '0;
        bus.reg_we_ma  = 1'b0;
        bus.reg_wdata  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_cnt    = 0;
        set_idle();
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;

        // Reset state
        bus.rs_id   = {5'd3, 5'd5};
        bus.opnd_id = {32'h3333, 32'h5555};
        #1;
        check_eq("rst_cnt", 64'(bus.stall_cnt), 64'd0);
        check_eq("rst_src", 64'(bus.fwd_src), 64'd0);
        tick(1'b1);

        // EX forward to both ports
        bus.rd_ex = 5'd5; bus.reg_we_ex = 1'b1; bus.alu_result = 32'h11;
        bus.rs_id = {5'd5, 5'd5};
        #1;
        check_eq("ex_opnd0", 64'(bus.opnd[31:0]), 64'h11);
        check_eq("ex_opnd1", 64'(bus.opnd[63:32]), 64'h11);
        check_eq("ex_src", 64'(bus.fwd_src), 64'(6'b001_001));
        check_eq("ex_stall", 64'(bus.stall), 64'd0);
        tick(1'b1);

        // Priority EX > MA > HIST0
        set_idle();
        bus.advance = 1'b1; bus.rd_ma = 5'd3; bus.reg_we_ma = 1'b1; bus.reg_wdata = 32'hCC;
        tick(1'b1);
        bus.advance = 1'b0;
        bus.rd_ex = 5'd3; bus.reg_we_ex = 1'b1; bus.alu_result = 32'hAA;
        bus.rd_ma = 5'd3; bus.reg_we_ma = 1'b1; bus.reg_wdata = 32'hBB;
        bus.rs_id = {5'd0, 5'd3};
        #1 check_eq("prio_ex", 64'(bus.opnd[31:0]), 64'hAA);
        tick(1'b1);
        bus.reg_we_ex = 1'b0;
        #1 check_eq("prio_ma", 64'(bus.opnd[31:0]), 64'hBB);
        tick(1'b1);
        bus.reg_we_ma = 1'b0;
        #1;
        check_eq("prio_hist", 64'(bus.opnd[31:0]), 64'hCC);
        check_eq("prio_hsrc", 64'(bus.fwd_src[2:0]), 64'd3);
        tick(1'b1);

        // x0 never forwards
        set_idle();
        bus.reg_we_ex = 1'b1; bus.alu_result = 32'h77;
        bus.reg_we_ma = 1'b1; bus.reg_wdata = 32'h88;
        #1;
        check_eq("x0_src", 64'(bus.fwd_src[2:0]), 64'd0);
        check_eq("x0_opnd", 64'(bus.opnd[31:0]), 64'd0);
        tick(1'b1);

        // Load-use stall, then MA forward of load data
        set_idle();
        bus.is_load_ex = 1'b1; bus.rd_ex = 5'd7; bus.reg_we_ex = 1'b1; bus.alu_result = 32'h100;
        bus.rs_id = {5'd7, 5'd0}; bus.rs_used = 2'b10;
        #1 check_eq("lu_stall", 64'(bus.stall), 64'd1);
        tick(1'b1);
        check_eq("lu_cnt", 64'(bus.stall_cnt), 64'd1);
        set_idle();
        bus.rd_ma = 5'd7; bus.reg_we_ma = 1'b1; bus.reg_wdata = 32'hDEAD; bus.advance = 1'b1;
        bus.rs_id = {5'd7, 5'd0}; bus.rs_used = 2'b10;
        #1;
        check_eq("lu_fwd", 64'(bus.opnd[63:32]), 64'hDEAD);
        check_eq("lu_nostall", 64'(bus.stall), 64'd0);
        tick(1'b1);
        set_idle();
        bus.is_load_ex = 1'b1; bus.rd_ex = 5'd7; bus.reg_we_ex = 1'b1;
        bus.rs_id = {5'd7, 5'd0}; bus.rs_used = 2'b01; bus.opnd_id = {32'h707, 32'h0};
        #1;
        check_eq("lu_unused", 64'(bus.stall), 64'd0);
        check_eq("lu_unused_src", 64'(bus.fwd_src[5:3]), 64'd0);
        tick(1'b1);

        // History shift and hold
        set_idle();
        bus.advance = 1'b1; bus.reg_we_ma = 1'b1;
        bus.rd_ma = 5'd4; bus.reg_wdata = 32'h44;
        tick(1'b1);
        bus.rd_ma = 5'd6; bus.reg_wdata = 32'h66;
        tick(1'b1);
        bus.advance = 1'b0; bus.reg_we_ma = 1'b0; bus.rd_ma = 5'd0;
        bus.rs_id = {5'd6, 5'd4}; bus.opnd_id = {32'h600, 32'h400};
        repeat (4) begin
            #1;
            check_eq("hold_h1", 64'(bus.opnd[31:0]), 64'h44);
            check_eq("hold_h0", 64'(bus.fwd_src[5:3]), 64'd3);
            tick(1'b1);
        end
        bus.advance = 1'b1; bus.reg_we_ma = 1'b1;
        tick(1'b1);
        bus.advance = 1'b0; bus.reg_we_ma = 1'b0;
        #1;
        check_eq("drop_src", 64'(bus.fwd_src[2:0]), 64'd0);
        check_eq("drop_opnd", 64'(bus.opnd[31:0]), 64'h400);
        check_eq("drop_h1", 64'(bus.fwd_src[5:3]), 64'd4);
        tick(1'b1);

        // Counter saturation, then reset clears counter and history
        set_idle();
        bus.advance = 1'b1; bus.rd_ma = 5'd10; bus.reg_we_ma = 1'b1; bus.reg_wdata = 32'hA0;
        tick(1'b1);
        set_idle();
        bus.is_load_ex = 1'b1; bus.rd_ex = 5'd9; bus.reg_we_ex = 1'b1;
        bus.rs_id = {5'd10, 5'd9}; bus.rs_used = 2'b01;
        repeat (20) tick(1'b1);
        check_eq("sat_cnt", 64'(bus.stall_cnt), 64'd15);
        reset = 1'b1;
        #1 check_eq("rst_stall", 64'(bus.stall), 64'd1);
        tick(1'b1);
        reset = 1'b0;
        #1;
        check_eq("rst_cnt2", 64'(bus.stall_cnt), 64'd0);
        check_eq("rst_hist", 64'(bus.fwd_src[5:3]), 64'd0);
        tick(1'b1);

        // Random traffic on a small register window to provoke matches
        repeat (400) begin
            bus.advance    = 1'($urandom_range(0, 1));
            bus.rs_id      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.rs_used    = 2'($urandom_range(0, 3));
            bus.opnd_id    = {$urandom(), $urandom()};
            bus.rd_ex      = 5'($urandom_range(0, 7));
            bus.reg_we_ex  = 1'($urandom_range(0, 1));
            bus.is_load_ex = ($urandom_range(0, 3) == 0);
            bus.alu_result = $urandom();
            bus.rd_ma      = 5'($urandom_range(0, 7));
            bus.reg_we_ma  = 1'($urandom_range(0, 1));
            bus.reg_wdata  = $urandom();
            reset          = ($urandom_range(0, 39) == 0);
            tick(1'b1);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
